bus_dma_master: RTL

- Unibus master (initiator) engine that lets the ARM run single PDP-11 bus cycles (DATI/DATIP/DATO/DATOB) against any slave.
- Handles NPR arbitration, SACK/BBSY takeover, address deskew and MSYN/SSYN handshake.
- Sits beside the slave-side register devices on the same a/c/d bus lines, so the ARM-side emulator can test memory and devices and move data blocks.

---
 rtl/bus_dma_master_if.sv | 25 ++
 rtl/bus_dma_master.sv | 105 ++++++++++
 2 files changed

// File: rtl/bus_dma_master_if.sv
// bus_dma_master_if: Unibus master-side signal bundle.
//   master modport: drives a/c/d, msyn, npr, sack, bbsy; receives d_in_h, ssyn, npg, bbsy_in, init.
//   slave modport:  the mirror view, used by whatever models the rest of the bus.
interface bus_dma_master_if;
    logic [17:0] a_out_h;
    logic [1:0]  c_out_h;
    logic [15:0] d_out_h;
    logic        msyn_out_h;
    logic        npr_out_h;
    logic        sack_out_h;
    logic        bbsy_out_h;
    logic [15:0] d_in_h;
    logic        ssyn_in_h;
    logic        npg_in_h;
    logic        bbsy_in_h;
    logic        init_in_h;
    modport master (
        output a_out_h, c_out_h, d_out_h, msyn_out_h, npr_out_h, sack_out_h, bbsy_out_h,
        input  d_in_h, ssyn_in_h, npg_in_h, bbsy_in_h, init_in_h
    );
    modport slave (
        input  a_out_h, c_out_h, d_out_h, msyn_out_h, npr_out_h, sack_out_h, bbsy_out_h,
        output d_in_h, ssyn_in_h, npg_in_h, bbsy_in_h, init_in_h
    );
endinterface

// File: rtl/bus_dma_master.sv
// bus_dma_master: ARM-driven Unibus master running single DATI/DATIP/DATO/DATOB cycles.
//   CLOCK, RESET          : clock, synchronous active-high reset
//   armwrite/armwaddr/armwdata : ARM register write port (regs 1 = control/addr, 2 = wdata)
//   armraddr/armrdata     : ARM register read port (combinational)
//   armintrq              : mirrors the done bit
//   bus                   : Unibus master signals (NPR/SACK/BBSY arbitration, MSYN/SSYN handshake)
module bus_dma_master #(
    parameter int DESKEW  = 8,
    parameter int TIMEOUT = 1000
) (
    input  logic                     CLOCK,
    input  logic                     RESET,
    input  logic                     armwrite,
    input  logic [1:0]               armraddr,
    input  logic [1:0]               armwaddr,
    input  logic [31:0]              armwdata,
    output logic [31:0]              armrdata,
    output logic                     armintrq,
    bus_dma_master_if.master         bus
);
    typedef enum logic [2:0] {IDLE, REQ, GRANT, SETUP, WAITS, DATA, WAITN, FIN} state_t;
    state_t      state, state_n;
    logic [15:0] cnt;
    logic        busy, done;
    logic [1:0]  err, func;
    logic [17:0] addr;
    logic [15:0] wdata, rdata;
    logic        wr1, wr2, t_last, d_last, on_bus;
    assign wr1    = armwrite && !busy && armwaddr == 2'd1;
    assign wr2    = armwrite && !busy && armwaddr == 2'd2;
    // cnt holds the number of cycles already spent in the current state,
    // so comparing against N-1 makes the state last exactly N cycles.
    assign t_last = cnt == 16'(TIMEOUT - 1);
    assign d_last = cnt == 16'(DESKEW - 1);
    assign on_bus = state inside {SETUP, WAITS, DATA, WAITN};
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = wr1 && armwdata[31] ? REQ : IDLE;
            REQ:     state_n = bus.npg_in_h ? GRANT : t_last ? FIN : REQ;
            GRANT:   state_n = !bus.bbsy_in_h && !bus.ssyn_in_h ? SETUP : GRANT;
            SETUP:   state_n = d_last ? WAITS : SETUP;
            WAITS:   state_n = bus.ssyn_in_h ? DATA : t_last ? FIN : WAITS;
            DATA:    state_n = WAITN;
            WAITN:   state_n = !bus.ssyn_in_h || t_last ? FIN : WAITN;
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            err   <= '0;
            func  <= '0;
            addr  <= '0;
            wdata <= '0;
            rdata <= '0;
        end else if (bus.init_in_h) begin
            state <= IDLE;
            cnt   <= '0;
            if (busy) begin
                busy <= 1'b0;
                done <= 1'b1;
                err  <= 2'd3;
            end
        end else begin
            state <= state_n;
            cnt   <= state_n != state ? '0 : cnt + 16'd1;
            if (wr1) begin
                addr <= armwdata[17:0];
                func <= armwdata[29:28];
                done <= 1'b0;
                err  <= '0;
                busy <= armwdata[31];
            end
            if (wr2)
                wdata <= armwdata[15:0];
            if (state == REQ && !bus.npg_in_h && t_last)
                err <= 2'd1;
            // WAITN only errors if SSYN is still asserted at the deadline
            if (t_last && ((state == WAITS && !bus.ssyn_in_h) || (state == WAITN && bus.ssyn_in_h)))
                err <= 2'd2;
            if (state == DATA && !func[1])
                rdata <= bus.d_in_h;
            if (state == FIN) begin
                busy <= 1'b0;
                done <= 1'b1;
            end
        end
    end
    // Bus outputs decode the registered state, so they change one cycle after a transition is decided.
    assign bus.npr_out_h  = state == REQ;
    assign bus.sack_out_h = state == GRANT;
    assign bus.bbsy_out_h = on_bus;
    assign bus.msyn_out_h = state == WAITS || state == DATA;
    assign bus.a_out_h    = on_bus ? addr : '0;
    assign bus.c_out_h    = on_bus ? func : '0;
    assign bus.d_out_h    = on_bus && func[1] ? wdata : '0;
    assign armintrq       = done;
    assign armrdata = armraddr == 2'd0 ? 32'h444D1001 :
                      armraddr == 2'd1 ? {busy, done, func, err, 8'h00, addr} :
                      armraddr == 2'd2 ? {rdata, wdata} : 32'hDEADBEEF;
endmodule
